// File: rtl/mem.sv
// Memory-access stage of the multi-cycle CPU.
// Unpacks the EXE->MEM bus and issues loads/stores to a synchronous data RAM.
// Loads wait out the RAM read latency, and the read data is aligned and extended here.
// MEM_over pulses for one cycle when the MEM->WB bus carries a valid result.
module mem #(
    parameter int LOAD_LATENCY = 1
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         MEM_valid,
    input  logic [105:0] EXE_MEM_bus_r,
    output logic [31:0]  dm_addr,
    output logic [3:0]   dm_wen,
    output logic [31:0]  dm_wdata,
    input  logic [31:0]  dm_rdata,
    output logic         MEM_over,
    output logic [69:0]  MEM_WB_bus,
    output logic [31:0]  MEM_pc
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;
    localparam logic [2:0] LAT  = 3'(LOAD_LATENCY);

    logic        inst_load, inst_store, ls_word, lb_sign;
    logic [31:0] store_data, alu_result, pc;
    logic        rf_wen;
    logic [4:0]  rf_wdest;

    assign {inst_load, inst_store, ls_word, lb_sign,
            store_data, alu_result, rf_wen, rf_wdest, pc} = EXE_MEM_bus_r;

    logic [1:0] state, state_nxt;
    logic [2:0] cnt;
    logic [7:0] ld_byte;
    logic [31:0] load_data, mem_result;

    // A load+store combination behaves as a load, so it never writes.
    logic do_store;
    assign do_store = inst_store & ~inst_load;

    // Next-state: new ops start only from IDLE; DONE holds until MEM_valid drops.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (MEM_valid) state_nxt = inst_load ? WAIT : DONE;
            WAIT:    if (!MEM_valid) state_nxt = IDLE;
                     else if (cnt == LAT) state_nxt = DONE;
            DONE:    if (!MEM_valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State and latency counter; cnt counts cycles since the load address went out.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && MEM_valid && inst_load)
                cnt <= 3'd1;
            else if (state == WAIT && MEM_valid && cnt < LAT)
                cnt <= cnt + 3'd1;
        end
    end

    assign MEM_over = MEM_valid &
                      (((state == IDLE) && !inst_load) ||
                       ((state == WAIT) && (cnt == LAT)));

    // Write enables exist only in the accepting IDLE cycle of a store.
    always_comb begin
        dm_wen = 4'b0000;
        if (state == IDLE && MEM_valid && do_store)
            dm_wen = ls_word ? 4'b1111 : (4'b0001 << alu_result[1:0]);
    end

    assign dm_addr  = {alu_result[31:2], 2'b00};
    assign dm_wdata = ls_word ? store_data : {4{store_data[7:0]}};

    // Byte lane pick and sign/zero extension of load data.
    assign ld_byte    = dm_rdata[{alu_result[1:0], 3'b000} +: 8];
    assign load_data  = ls_word ? dm_rdata : {{24{lb_sign & ld_byte[7]}}, ld_byte};
    assign mem_result = inst_load ? load_data : alu_result;

    assign MEM_WB_bus = {rf_wen, rf_wdest, mem_result, pc};
    assign MEM_pc     = pc;

endmodule

// File: tb/tb_mem.sv
// Self-checking bench for mem: directed vector table, reset-in-WAIT sequence,
// then random ops checked against a byte-array memory model.
module tb_mem;

    logic         clk = 1'b0;
    logic         resetn;
    logic         init_ram;
    logic [105:0] bus;
    logic         v1, v3, sel;
    logic [31:0]  a1, a3, wd1, wd3, pc1, pc3, rd1, rd3;
    logic [3:0]   wen1, wen3;
    logic         ov1, ov3;
    logic [69:0]  wb1, wb3;

    always #5 clk = ~clk;

    mem #(.LOAD_LATENCY(1)) u_mem1 (
        .clk(clk), .resetn(resetn), .MEM_valid(v1), .EXE_MEM_bus_r(bus),
        .dm_addr(a1), .dm_wen(wen1), .dm_wdata(wd1), .dm_rdata(rd1),
        .MEM_over(ov1), .MEM_WB_bus(wb1), .MEM_pc(pc1));

    mem #(.LOAD_LATENCY(3)) u_mem3 (
        .clk(clk), .resetn(resetn), .MEM_valid(v3), .EXE_MEM_bus_r(bus),
        .dm_addr(a3), .dm_wen(wen3), .dm_wdata(wd3), .dm_rdata(rd3),
        .MEM_over(ov3), .MEM_WB_bus(wb3), .MEM_pc(pc3));

    logic        cur_over;
    logic [3:0]  cur_wen;
    logic [31:0] cur_wd, cur_addr, cur_pc;
    logic [69:0] cur_wb;
    assign cur_over = sel ? ov3  : ov1;
    assign cur_wen  = sel ? wen3 : wen1;
    assign cur_wd   = sel ? wd3  : wd1;
    assign cur_addr = sel ? a3   : a1;
    assign cur_pc   = sel ? pc3  : pc1;
    assign cur_wb   = sel ? wb3  : wb1;

    // Initial memory contents: word 0x20 holds 0x80F00102, the rest a byte pattern.
    function automatic logic [7:0] byte_init(input int b);
        case (b)
            32: return 8'h02;
            33: return 8'h01;
            34: return 8'hF0;
            35: return 8'h80;
            default: return 8'(b) ^ 8'h5A;
        endcase
    endfunction

    // Data RAM environment: 256 bytes, read pipeline gives latency 1 and 3 taps.
    logic [31:0] ram [0:63];
    logic [31:0] rpipe [0:2];
    logic [3:0]  wen_any;
    logic [31:0] wd_sel;
    assign wen_any = wen1 | wen3;
    assign wd_sel  = (wen1 != 4'b0) ? wd1 : wd3;
    assign rd1 = rpipe[0];
    assign rd3 = rpipe[2];

    always @(posedge clk) begin
        rpipe[0] <= ram[a1[7:2]];
        rpipe[1] <= rpipe[0];
        rpipe[2] <= rpipe[1];
        if (init_ram) begin
            for (int i = 0; i < 64; i++)
                ram[i] <= {byte_init(4*i+3), byte_init(4*i+2), byte_init(4*i+1), byte_init(4*i)};
        end else begin
            for (int k = 0; k < 4; k++)
                if (wen_any[k]) ram[a1[7:2]][8*k +: 8] <= wd_sel[8*k +: 8];
        end
    end

    // Reference model: plain byte array.
    logic [7:0] ref_mem [0:255];

    task automatic model_op(input logic ld, st, w, sg, input logic [31:0] sd, alu,
                            output logic [31:0] res, output logic [3:0] wen,
                            output logic [31:0] wd);
        int a, base;
        logic [7:0] b;
        a    = int'(alu[7:0]);
        base = a - (a % 4);
        res  = alu;
        wen  = 4'b0;
        wd   = w ? sd : {4{sd[7:0]}};
        if (ld) begin
            if (w) res = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
            else begin
                b   = ref_mem[a];
                res = (sg && b[7]) ? {24'hFFFFFF, b} : {24'h0, b};
            end
        end else if (st) begin
            if (w) begin
                for (int k = 0; k < 4; k++) ref_mem[base+k] = sd[8*k +: 8];
                wen = 4'hF;
            end else begin
                ref_mem[a] = sd[7:0];
                wen = 4'(1 << (a % 4));
            end
        end
    endtask

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [69:0] act, input logic [69:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [105:0] mkbus(input logic ld, st, w, sg, input logic [31:0] sd, alu,
                                           input logic rfw, input logic [4:0] rfd,
                                           input logic [31:0] pc);
        return {ld, st, w, sg, sd, alu, rfw, rfd, pc};
    endfunction

    // Drive one op for 'hold' cycles with MEM_valid high, then one low cycle.
    task automatic run_op(input bit s3, input logic [105:0] b, input int hold,
                          output int first, output int nover, output logic [69:0] wbv,
                          output logic [31:0] pcv, output logic [3:0] wen0,
                          output logic [31:0] wd0, output logic [31:0] addr0,
                          output int late);
        bus = b; sel = s3;
        if (s3) v3 = 1'b1; else v1 = 1'b1;
        first = -1; nover = 0; late = 0; wbv = '0; pcv = '0;
        wen0 = '0; wd0 = '0; addr0 = '0;
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            if (c == 0) begin
                wen0 = cur_wen; wd0 = cur_wd; addr0 = cur_addr;
            end else if (cur_wen != 4'b0) late++;
            if (cur_over) begin
                nover++;
                if (first < 0) begin first = c; wbv = cur_wb; pcv = cur_pc; end
            end
            @(posedge clk); #1;
        end
        v1 = 1'b0; v3 = 1'b0;
        @(negedge clk);
        if (cur_over) nover++;
        if (cur_wen != 4'b0) late++;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          s3;
        logic        ld, st, w, sg;
        logic [31:0] sd, alu;
        logic        rfw;
        logic [4:0]  rfd;
        logic [31:0] pc;
        int          hold;
        int          first;
        logic [3:0]  wen;
        logic [31:0] wd;
        logic [31:0] res;
    } vec_t;

    function automatic vec_t mk(input bit s3, input logic ld, st, w, sg,
                                input logic [31:0] sd, alu, input logic rfw,
                                input logic [4:0] rfd, input logic [31:0] pc,
                                input int hold, first, input logic [3:0] wen,
                                input logic [31:0] wd, res);
        vec_t v;
        v.s3 = s3; v.ld = ld; v.st = st; v.w = w; v.sg = sg; v.sd = sd; v.alu = alu;
        v.rfw = rfw; v.rfd = rfd; v.pc = pc; v.hold = hold; v.first = first;
        v.wen = wen; v.wd = wd; v.res = res;
        return v;
    endfunction

    task automatic check_op(input string nm, input bit s3, input logic ld, st, w, sg,
                            input logic [31:0] sd, alu, input logic rfw,
                            input logic [4:0] rfd, input logic [31:0] pc, input int hold,
                            input int efirst, input logic [3:0] ewen,
                            input logic [31:0] ewd, eres);
        int first, nover, late;
        logic [69:0] wbv;
        logic [31:0] pcv, wd0, addr0;
        logic [3:0]  wen0;
        run_op(s3, mkbus(ld, st, w, sg, sd, alu, rfw, rfd, pc), hold,
               first, nover, wbv, pcv, wen0, wd0, addr0, late);
        chk({nm, " over_cycle"}, 70'(first), 70'(efirst));
        chk({nm, " over_count"}, 70'(nover), (efirst < 0) ? 70'd0 : 70'd1);
        chk({nm, " wen0"}, 70'(wen0), 70'(ewen));
        chk({nm, " addr"}, 70'(addr0), 70'({alu[31:2], 2'b00}));
        chk({nm, " late_wen"}, 70'(late), 70'd0);
        if (st && !ld) chk({nm, " wdata"}, 70'(wd0), 70'(ewd));
        if (efirst >= 0) begin
            chk({nm, " wb_bus"}, wbv, {rfw, rfd, eres, pc});
            chk({nm, " mem_pc"}, 70'(pcv), 70'(pc));
        end
    endtask

    vec_t tbl [12];

    initial begin
        logic [31:0] eres, ewd, alu, sd, pc;
        logic [3:0]  ewen;
        logic        ld, st, w, sg;
        int          efirst, hold;
        bit          s3;

        tbl[0]  = mk(0, 0,1,1,0, 32'h12345678, 32'h14, 0, 5'd0, 32'h100, 3, 0, 4'hF, 32'h12345678, 32'h14);
        tbl[1]  = mk(0, 0,1,0,0, 32'h000000AB, 32'h17, 0, 5'd0, 32'h104, 3, 0, 4'h8, 32'hABABABAB, 32'h17);
        tbl[2]  = mk(0, 1,0,1,0, 32'h0, 32'h20, 1, 5'd3, 32'h108, 2, 1, 4'h0, 32'h0, 32'h80F00102);
        tbl[3]  = mk(0, 1,0,0,1, 32'h0, 32'h23, 1, 5'd4, 32'h10C, 2, 1, 4'h0, 32'h0, 32'hFFFFFF80);
        tbl[4]  = mk(0, 1,0,0,0, 32'h0, 32'h23, 1, 5'd6, 32'h110, 2, 1, 4'h0, 32'h0, 32'h00000080);
        tbl[5]  = mk(0, 1,0,0,1, 32'h0, 32'h21, 1, 5'd7, 32'h114, 2, 1, 4'h0, 32'h0, 32'h00000001);
        tbl[6]  = mk(0, 1,1,1,0, 32'hDEADBEEF, 32'h20, 1, 5'd8, 32'h118, 3, 1, 4'h0, 32'h0, 32'h80F00102);
        tbl[7]  = mk(0, 1,0,1,0, 32'h0, 32'h22, 1, 5'd9, 32'h11C, 2, 1, 4'h0, 32'h0, 32'h80F00102);
        tbl[8]  = mk(1, 1,0,1,0, 32'h0, 32'h20, 1, 5'd10, 32'h120, 5, 3, 4'h0, 32'h0, 32'h80F00102);
        tbl[9]  = mk(1, 1,0,1,0, 32'h0, 32'h20, 1, 5'd11, 32'h124, 2, -1, 4'h0, 32'h0, 32'h0);
        tbl[10] = mk(1, 0,0,0,0, 32'h0, 32'h7, 1, 5'd5, 32'hBFC00010, 2, 0, 4'h0, 32'h0, 32'h7);
        tbl[11] = mk(0, 1,0,1,0, 32'h0, 32'h14, 1, 5'd12, 32'h128, 2, 1, 4'h0, 32'h0, 32'hAB345678);

        for (int i = 0; i < 256; i++) ref_mem[i] = byte_init(i);

        // Reset with the bus carrying a misaligned address.
        resetn = 1'b0; init_ram = 1'b1; v1 = 1'b0; v3 = 1'b0; sel = 1'b0;
        bus = mkbus(0, 1, 0, 0, 32'h0, 32'h1234567B, 0, 5'd0, 32'hBFC00000);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("reset over1", 70'(ov1), 70'd0);
        chk("reset over3", 70'(ov3), 70'd0);
        chk("reset wen", 70'(wen1 | wen3), 70'd0);
        chk("reset addr", 70'(a1), 70'h12345678);
        chk("reset pc", 70'(pc1), 70'hBFC00000);
        @(posedge clk); #1;
        resetn = 1'b1; init_ram = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) begin
            model_op(tbl[i].ld, tbl[i].st, tbl[i].w, tbl[i].sg, tbl[i].sd, tbl[i].alu,
                     eres, ewen, ewd);
            check_op($sformatf("vec%0d", i), tbl[i].s3, tbl[i].ld, tbl[i].st, tbl[i].w,
                     tbl[i].sg, tbl[i].sd, tbl[i].alu, tbl[i].rfw, tbl[i].rfd, tbl[i].pc,
                     tbl[i].hold, tbl[i].first, tbl[i].wen, tbl[i].wd, tbl[i].res);
        end

        // Reset while a latency-3 load sits in WAIT.
        bus = mkbus(1, 0, 1, 0, 32'h0, 32'h20, 1, 5'd1, 32'h200);
        sel = 1'b1; v3 = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        resetn = 1'b0; v3 = 1'b0;
        @(negedge clk);
        chk("rst_wait over", 70'(ov3), 70'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_wait over_after", 70'(ov3), 70'd0);
        chk("rst_wait wen_after", 70'(wen3), 70'd0);
        @(posedge clk); #1;
        check_op("post_rst load", 1, 1, 0, 1, 0, 32'h0, 32'h20, 1, 5'd2, 32'h204,
                 4, 3, 4'h0, 32'h0, 32'h80F00102);

        // Random ops against the byte-array model.
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            ld = (kind >= 6);
            st = (kind >= 3 && kind <= 5) || (kind == 9);
            w  = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sd = $urandom; alu = $urandom; pc = $urandom;
            s3 = bit'($urandom_range(0, 1));
            efirst = ld ? (s3 ? 3 : 1) : 0;
            if (ld && s3 && $urandom_range(0, 4) == 0) begin
                hold = $urandom_range(1, 3);
                efirst = -1;
            end else
                hold = efirst + 1 + $urandom_range(0, 2);
            model_op(ld, st, w, sg, sd, alu, eres, ewen, ewd);
            check_op($sformatf("rnd%0d", n), s3, ld, st, w, sg, sd, alu, 1'b1,
                     5'(n), pc, hold, efirst, ewen, ewd, eres);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
